// File: rtl/astropix3_readout_frame_assembler.sv
// Astropix3 readout frame assembler: strips idle filler from the MISO byte stream,
// aligns on headers and exposes only fully received frames through a staging FIFO.
module astropix3_readout_frame_assembler #(
  parameter int PAYLOAD_BYTES = 4,
  parameter int FIFO_AW       = 4
) (
  input  logic        clk,
  input  logic        resn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        stat_clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_first,
  output logic        out_last,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_drops,
  output logic [15:0] stat_sync_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a byte leaves on every rising edge where out_valid && out_ready;
  // out_data/out_first/out_last hold steady while out_valid && !out_ready.
  // The input side has no backpressure: in_valid alone means a byte is present.

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
  localparam logic [3:0]    PB       = 4'(PAYLOAD_BYTES);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DISCARD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      rem_q, rem_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [9:0]      rd_word_q, rd_word_d;
  logic [15:0]     frames_q, frames_d;
  logic [15:0]     drops_q, drops_d;
  logic [15:0]     sync_err_q, sync_err_d;
  logic [9:0]      mem_q [DEPTH];

  logic            wr_en;
  logic [9:0]      wr_word;
  logic            inc_frames, inc_drops, inc_sync;
  logic            full, pop, is_idle, is_header;
  logic [FIFO_AW-1:0] rd_addr;

  assign is_idle   = (in_data == 8'hBC) || (in_data == 8'hFF);
  assign is_header = (in_data[7:5] == 3'b001);
  // Full uses registered pointers only, so a same-cycle pop cannot make room.
  assign full      = ((wr_ptr_q - rd_ptr_q) == PTR_FULL);
  assign out_valid = (commit_ptr_q != rd_ptr_q);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    wr_en        = 1'b0;
    wr_word      = '0;
    inc_frames   = 1'b0;
    inc_drops    = 1'b0;
    inc_sync     = 1'b0;
    if (in_valid) begin
      case (state_q)
        ST_HUNT: begin
          if (!is_idle) begin
            if (is_header) begin
              rem_d = PB;
              if (full) begin
                inc_drops = 1'b1;
                wr_ptr_d  = commit_ptr_q;
                state_d   = ST_DISCARD;
              end else begin
                wr_en    = 1'b1;
                wr_word  = {1'b1, 1'b0, in_data};
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                state_d  = ST_PAYLOAD;
              end
            end else begin
              inc_sync = 1'b1;
            end
          end
        end
        ST_PAYLOAD: begin
          rem_d = rem_q - 4'd1;
          if (full) begin
            // Rewind drops the partial frame; remaining bytes are skipped in DISCARD.
            inc_drops = 1'b1;
            wr_ptr_d  = commit_ptr_q;
            state_d   = (rem_q == 4'd1) ? ST_HUNT : ST_DISCARD;
          end else begin
            wr_en    = 1'b1;
            wr_word  = {1'b0, (rem_q == 4'd1), in_data};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rem_q == 4'd1) begin
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              inc_frames   = 1'b1;
              state_d      = ST_HUNT;
            end
          end
        end
        ST_DISCARD: begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_HUNT;
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Registered read port prefetches the entry at the next read pointer; the bypass
  // covers a write landing on that slot in the same cycle.
  always_comb begin
    rd_ptr_d  = rd_ptr_q + (pop ? PTR_ONE : '0);
    rd_addr   = rd_ptr_d[FIFO_AW-1:0];
    rd_word_d = (wr_en && (wr_ptr_q[FIFO_AW-1:0] == rd_addr)) ? wr_word : mem_q[rd_addr];
  end

  always_comb begin
    frames_d   = stat_clear ? 16'd0 : frames_q + {15'd0, inc_frames};
    drops_d    = stat_clear ? 16'd0 :
                 (inc_drops && drops_q != 16'hFFFF) ? drops_q + 16'd1 : drops_q;
    sync_err_d = stat_clear ? 16'd0 :
                 (inc_sync && sync_err_q != 16'hFFFF) ? sync_err_q + 16'd1 : sync_err_q;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= wr_word;
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      state_q      <= ST_HUNT;
      rem_q        <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      rd_word_q    <= '0;
      frames_q     <= '0;
      drops_q      <= '0;
      sync_err_q   <= '0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_word_q    <= rd_word_d;
      frames_q     <= frames_d;
      drops_q      <= drops_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign out_first     = rd_word_q[9];
  assign out_last      = rd_word_q[8];
  assign out_data      = rd_word_q[7:0];
  assign stat_frames   = frames_q;
  assign stat_drops    = drops_q;
  assign stat_sync_err = sync_err_q;
  assign dbg_state     = state_q;

endmodule
